shape_rom_sched: RTL

Burst scheduler that shares the single-port shape ROM (4-bit shape select, 6-bit row address, 51-bit row data, one-cycle registered-address latency) between two requesters: the render pipeline (port 0) and the game-logic collision checker (port 1). Each request names a shape, a start row and a row count. The block arbitrates at burst granularity, sweeps the ROM address, and returns tagged row data plus a completion pulse. It sits directly between both clients and the ROM instance; it is the ROM's only driver.

---
 rtl/shape_rom_sched.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/shape_rom_sched.sv
// Burst scheduler sharing the single-port shape ROM between render (port 0) and collision (port 1).
// Build option: define SHAPE_SCHED_FIXED_PRIO_EN to give port 0 fixed priority instead of round-robin.
module shape_rom_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [3:0]  shape0,
    input  logic [3:0]  shape1,
    input  logic [5:0]  start0,
    input  logic [5:0]  start1,
    input  logic [5:0]  len0,
    input  logic [5:0]  len1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [3:0]  rom_dataret,
    output logic [5:0]  rom_address,
    input  logic [50:0] rom_outdata,
    output logic        row_valid,
    output logic [50:0] row_data,
    output logic        row_owner,
    output logic [5:0]  row_index,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  len_q, len_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [5:0]  addr_q, addr_d;
    logic [3:0]  shp_q, shp_d;
    logic        owner_q, owner_d;
    logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic        done0_q, done0_d, done1_q, done1_d;
    logic        busy_q;
    logic        p1_v_q, p1_own_q;
    logic [5:0]  p1_idx_q;
    logic        row_valid_q, row_owner_q;
    logic [5:0]  row_index_q;
    logic [50:0] row_data_q;
    logic        grant_s;
    logic        win_s;
    logic [5:0]  win_len_s;

    assign grant_s = (state_q == IDLE) && (req0 || req1);

`ifdef SHAPE_SCHED_FIXED_PRIO_EN
    // Port 0 always wins; port 1 is only served when port 0 is not requesting.
    always_comb begin
        win_s = ~req0;
    end
`else
    logic ptr_q;

    // Round-robin choice: on a tie the port not granted last wins.
    always_comb begin
        if (req0 && req1) begin
            win_s = ~ptr_q;
        end else begin
            win_s = req1;
        end
    end

    // Last-winner pointer, reset to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b1;
        end else if (grant_s) begin
            ptr_q <= win_s;
        end
    end
`endif

    assign win_len_s = win_s ? len1 : len0;

    // Next-state logic: arbitration, address sweep and completion.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        shp_d   = shp_q;
        owner_d = owner_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    owner_d = win_s;
                    gnt0_d  = ~win_s;
                    gnt1_d  = win_s;
                    shp_d   = win_s ? shape1 : shape0;
                    addr_d  = win_s ? start1 : start0;
                    len_d   = win_len_s;
                    cnt_d   = 6'd0;
                    // An empty burst still spends one cycle in DRAIN so done keeps its usual slot.
                    state_d = (win_len_s == 6'd0) ? DRAIN : SWEEP;
                end else begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                if (cnt_q == len_q - 6'd1) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d  = cnt_q + 6'd1;
                    addr_d = addr_q + 6'd1;
                end
            end
            DRAIN: begin
                state_d = DONE;
                done0_d = ~owner_q;
                done1_d = owner_q;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and ROM-address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= 6'd0;
            cnt_q   <= 6'd0;
            addr_q  <= 6'd0;
            shp_q   <= 4'd0;
            owner_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            shp_q   <= shp_d;
            owner_q <= owner_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Tag pipe: stage 1 lines up with the ROM output, stage 2 with the captured row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_v_q      <= 1'b0;
            p1_own_q    <= 1'b0;
            p1_idx_q    <= 6'd0;
            row_valid_q <= 1'b0;
            row_owner_q <= 1'b0;
            row_index_q <= 6'd0;
            row_data_q  <= 51'd0;
        end else begin
            p1_v_q      <= (state_q == SWEEP);
            p1_own_q    <= owner_q;
            p1_idx_q    <= cnt_q;
            row_valid_q <= p1_v_q;
            row_owner_q <= p1_own_q;
            row_index_q <= p1_idx_q;
            if (p1_v_q) begin
                row_data_q <= rom_outdata;
            end
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign rom_dataret = shp_q;
    assign rom_address = addr_q;
    assign row_valid   = row_valid_q;
    assign row_data    = row_data_q;
    assign row_owner   = row_owner_q;
    assign row_index   = row_index_q;
    assign busy        = busy_q;

endmodule
